maze_solver_param: RTL and testbench

Parametrised depth-first maze solver and the successor to the fixed 16x16 rat-in-maze top. Adds configurable grid size, configurable stack depth, run-time start/goal coordinates, stack-overflow detection and a cycle-accurate path replay mode. Drives an external 1-bit-per-cell maze RAM: 0 = free, 1 = wall or visited. Sits between the top-level sequencer and the maze RAM.

---
 rtl/maze_solver_param_if.sv | 42 ++++
 rtl/maze_solver_param.sv | 220 ++++++++++++++++++++++
 tb/tb_maze_solver_param.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_solver_param_if.sv
// Host/RAM bundle for the parametrised DFS maze solver.
// master : sequencer + maze RAM side (drives start/goal/run and mem_rdata)
// slave  : solver side (drives RAM strobes, status and replay outputs)
// path_len is log2(STK_DEPTH)+1 bits so a completely full stack is representable.
interface maze_solver_param_if #(
  parameter int ROW_W     = 4,
  parameter int COL_W     = 4,
  parameter int STK_DEPTH = 256
);
  localparam int PL_W = $clog2(STK_DEPTH) + 1;

  logic                   start;
  logic [ROW_W-1:0]       start_row;
  logic [COL_W-1:0]       start_col;
  logic [ROW_W-1:0]       goal_row;
  logic [COL_W-1:0]       goal_col;
  logic                   run;
  logic [ROW_W+COL_W-1:0] mem_addr;
  logic                   mem_rd;
  logic                   mem_wr;
  logic                   mem_wdata;
  logic                   mem_rdata;
  logic                   busy;
  logic                   done;
  logic                   fail;
  logic                   overflow;
  logic [PL_W-1:0]        path_len;
  logic                   move;
  logic [1:0]             move_dir;

  modport master (
    output start, start_row, start_col, goal_row, goal_col, run, mem_rdata,
    input  mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, fail, overflow,
           path_len, move, move_dir
  );

  modport slave (
    input  start, start_row, start_col, goal_row, goal_col, run, mem_rdata,
    output mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, fail, overflow,
           path_len, move, move_dir
  );
endinterface

// File: rtl/maze_solver_param.sv
// Parametrised depth-first maze solver with path replay.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : maze_solver_param_if.slave -- start/goal/run from the sequencer,
//              1-bit-per-cell RAM access (0 free, 1 wall/visited, read latency 1),
//              busy/done/fail/overflow status, path_len (= stack occupancy),
//              move/move_dir replay stream (0=N 1=E 2=S 3=W).
//
// state  | meaning
// IDLE   | waiting for start after reset
// MARK   | writing the visited mark at the current cell
// CHKG   | comparing current cell against the goal
// PROBE  | choosing the next direction to try / issuing the neighbour read
// RDW    | neighbour read in flight
// EVAL   | neighbour data valid: advance, skip, or overflow
// BACK   | popping the stack and stepping back
// DONE   | goal reached, path held on the stack
// FAIL   | no path or stack overflow
// REPLAY | streaming the stacked directions out as move pulses
module maze_solver_param #(
  parameter int ROW_W     = 4,
  parameter int COL_W     = 4,
  parameter int STK_DEPTH = 256
) (
  input logic                clk,
  input logic                rst,
  maze_solver_param_if.slave bus
);
  localparam int AW = $clog2(STK_DEPTH);
  localparam int PW = AW + 1;
  localparam int MW = ROW_W + COL_W;

  typedef enum logic [3:0] {
    S_IDLE, S_MARK, S_CHKG, S_PROBE, S_RDW, S_EVAL, S_BACK, S_DONE, S_FAIL, S_REPLAY
  } state_t;

  state_t           state;
  logic [ROW_W-1:0] cur_row, goal_row_q, nb_row, bk_row;
  logic [COL_W-1:0] cur_col, goal_col_q, nb_col, bk_col;
  logic [2:0]       dir;
  logic [PW-1:0]    sp, sp_m1;
  logic [AW-1:0]    rp;
  logic [1:0]       stk [STK_DEPTH];
  logic [1:0]       top_dir;
  logic             off_grid, stk_full;

  logic [MW-1:0]    mem_addr_q;
  logic             mem_rd_q, mem_wr_q;
  logic             busy_q, done_q, fail_q, ovf_q, move_q;
  logic [1:0]       move_dir_q;

  assign sp_m1    = sp - PW'(1);
  assign top_dir  = stk[sp_m1[AW-1:0]];
  assign stk_full = (sp == PW'(STK_DEPTH));

  // Neighbour in the direction under test; edge cells are flagged so no
  // wrapped address ever reaches the RAM.
  always_comb begin
    nb_row   = cur_row;
    nb_col   = cur_col;
    off_grid = 1'b0;
    case (dir[1:0])
      2'd0: begin
        off_grid = (cur_row == '0);
        nb_row   = cur_row - ROW_W'(1);
      end
      2'd1: begin
        off_grid = (cur_col == '1);
        nb_col   = cur_col + COL_W'(1);
      end
      2'd2: begin
        off_grid = (cur_row == '1);
        nb_row   = cur_row + ROW_W'(1);
      end
      default: begin
        off_grid = (cur_col == '0);
        nb_col   = cur_col - COL_W'(1);
      end
    endcase
  end

  // Cell we came from: step opposite to the direction on top of the stack.
  always_comb begin
    bk_row = cur_row;
    bk_col = cur_col;
    case (top_dir)
      2'd0:    bk_row = cur_row + ROW_W'(1);
      2'd1:    bk_col = cur_col - COL_W'(1);
      2'd2:    bk_row = cur_row - ROW_W'(1);
      default: bk_col = cur_col + COL_W'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cur_row    <= '0;
      cur_col    <= '0;
      goal_row_q <= '0;
      goal_col_q <= '0;
      dir        <= '0;
      sp         <= '0;
      rp         <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      ovf_q      <= 1'b0;
      move_q     <= 1'b0;
      move_dir_q <= '0;
    end else begin
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      move_q   <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (bus.start) begin
            goal_row_q <= bus.goal_row;
            goal_col_q <= bus.goal_col;
            cur_row    <= bus.start_row;
            cur_col    <= bus.start_col;
            dir        <= '0;
            sp         <= '0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b1;
            // strobe is registered so it is visible during MARK itself
            mem_wr_q   <= 1'b1;
            mem_addr_q <= {bus.start_row, bus.start_col};
            state      <= S_MARK;
          end else if (state == S_DONE && bus.run && sp != '0) begin
            rp     <= '0;
            busy_q <= 1'b1;
            state  <= S_REPLAY;
          end
        end
        S_MARK: state <= S_CHKG;
        S_CHKG: begin
          if (cur_row == goal_row_q && cur_col == goal_col_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_DONE;
          end else begin
            state <= S_PROBE;
          end
        end
        S_PROBE: begin
          if (dir[2]) begin
            state <= S_BACK;
          end else if (off_grid) begin
            dir <= dir + 3'd1;
          end else begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= {nb_row, nb_col};
            state      <= S_RDW;
          end
        end
        S_RDW: state <= S_EVAL;
        S_EVAL: begin
          if (bus.mem_rdata) begin
            dir   <= dir + 3'd1;
            state <= S_PROBE;
          end else if (stk_full) begin
            fail_q <= 1'b1;
            ovf_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_FAIL;
          end else begin
            stk[sp[AW-1:0]] <= dir[1:0];
            sp         <= sp + PW'(1);
            cur_row    <= nb_row;
            cur_col    <= nb_col;
            dir        <= '0;
            mem_wr_q   <= 1'b1;
            mem_addr_q <= {nb_row, nb_col};
            state      <= S_MARK;
          end
        end
        S_BACK: begin
          if (sp == '0) begin
            fail_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_FAIL;
          end else begin
            sp      <= sp_m1;
            cur_row <= bk_row;
            cur_col <= bk_col;
            dir     <= {1'b0, top_dir} + 3'd1;
            state   <= S_PROBE;
          end
        end
        S_REPLAY: begin
          move_q     <= 1'b1;
          move_dir_q <= stk[rp];
          rp         <= rp + AW'(1);
          if ({1'b0, rp} == sp_m1) begin
            busy_q <= 1'b0;
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_wdata = 1'b1;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.overflow  = ovf_q;
  assign bus.path_len  = sp;
  assign bus.move      = move_q;
  assign bus.move_dir  = move_dir_q;
endmodule

// File: tb/tb_maze_solver_param.sv
// Bench for maze_solver_param: two solvers (stack depth 256 and 4) share the
// host stimulus, each on its own RAM copy, and are compared against a
// queue-based DFS reference that also predicts cycle counts.
module tb_maze_solver_param;
  localparam int RW = 4;
  localparam int CW = 4;
  localparam int D0 = 256;
  localparam int D1 = 4;
  localparam int NC = 256;
  localparam int BOUND = 8000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start, run;
  logic [RW-1:0] s_row, g_row;
  logic [CW-1:0] s_col, g_col;

  maze_solver_param_if #(.ROW_W(RW), .COL_W(CW), .STK_DEPTH(D0)) bus0 ();
  maze_solver_param_if #(.ROW_W(RW), .COL_W(CW), .STK_DEPTH(D1)) bus1 ();

  assign bus0.start = start;  assign bus1.start = start;
  assign bus0.run = run;      assign bus1.run = run;
  assign bus0.start_row = s_row;  assign bus1.start_row = s_row;
  assign bus0.start_col = s_col;  assign bus1.start_col = s_col;
  assign bus0.goal_row = g_row;   assign bus1.goal_row = g_row;
  assign bus0.goal_col = g_col;   assign bus1.goal_col = g_col;

  maze_solver_param #(.ROW_W(RW), .COL_W(CW), .STK_DEPTH(D0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  maze_solver_param #(.ROW_W(RW), .COL_W(CW), .STK_DEPTH(D1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  // RAM models, monitors and replay capture (single writer per variable)
  logic          load_req = 1'b0;
  logic [NC-1:0] maze_img;
  logic          ram0 [NC];
  logic          ram1 [NC];
  logic          rdata0 = 1'b0, rdata1 = 1'b0;
  int            cyc = 0;
  int            rd0 = 0, wr0 = 0, dbl0 = 0, excl0 = 0;
  int            rd1 = 0, wr1 = 0, dbl1 = 0, excl1 = 0;
  int            mv0[$], mc0[$], mv1[$], mc1[$];

  assign bus0.mem_rdata = rdata0;
  assign bus1.mem_rdata = rdata1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_req) begin
      for (int i = 0; i < NC; i++) ram0[i] <= maze_img[i];
    end else begin
      if (bus0.mem_rd) begin
        rdata0 <= ram0[bus0.mem_addr];
        rd0    <= rd0 + 1;
      end
      if (bus0.mem_wr) begin
        if (ram0[bus0.mem_addr] || !bus0.mem_wdata) dbl0 <= dbl0 + 1;
        ram0[bus0.mem_addr] <= 1'b1;
        wr0 <= wr0 + 1;
      end
      if (bus0.mem_rd && bus0.mem_wr) excl0 <= excl0 + 1;
    end
    if (bus0.move) begin
      mv0.push_back(int'(bus0.move_dir));
      mc0.push_back(cyc);
    end
  end

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < NC; i++) ram1[i] <= maze_img[i];
    end else begin
      if (bus1.mem_rd) begin
        rdata1 <= ram1[bus1.mem_addr];
        rd1    <= rd1 + 1;
      end
      if (bus1.mem_wr) begin
        if (ram1[bus1.mem_addr] || !bus1.mem_wdata) dbl1 <= dbl1 + 1;
        ram1[bus1.mem_addr] <= 1'b1;
        wr1 <= wr1 + 1;
      end
      if (bus1.mem_rd && bus1.mem_wr) excl1 <= excl1 + 1;
    end
    if (bus1.move) begin
      mv1.push_back(int'(bus1.move_dir));
      mc1.push_back(cyc);
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference DFS: grid as plain integers, stack as a queue.
  // Cycle cost: each entered cell 2 (mark + goal check), an edge probe 1,
  // an in-grid probe 3 (probe, wait, evaluate), exhausted cell 2 (probe + back).
  task automatic model_solve(input logic [NC-1:0] mz, input int sr, input int sc,
                             input int gr, input int gc, input int depth,
                             output int e_done, output int e_fail, output int e_ovf,
                             output int e_reads, output int e_writes, output int e_cyc,
                             output int path[$]);
    logic [NC-1:0] vis;
    int r, c, d, nr, nc, p;
    int stk[$];
    bit fin;
    vis = mz; r = sr; c = sc; d = 0;
    e_done = 0; e_fail = 0; e_ovf = 0; e_reads = 0; e_writes = 1; e_cyc = 2;
    vis[r*16+c] = 1'b1;
    fin = (r == gr && c == gc);
    if (fin) e_done = 1;
    while (!fin) begin
      if (d == 4) begin
        e_cyc += 2;
        if (stk.size() == 0) begin
          e_fail = 1; fin = 1;
        end else begin
          p = stk.pop_back();
          case ((p + 2) % 4)
            0: r = r - 1;
            1: c = c + 1;
            2: r = r + 1;
            default: c = c - 1;
          endcase
          d = p + 1;
        end
      end else begin
        nr = r; nc = c;
        case (d)
          0: nr = r - 1;
          1: nc = c + 1;
          2: nr = r + 1;
          default: nc = c - 1;
        endcase
        if (nr < 0 || nr > 15 || nc < 0 || nc > 15) begin
          e_cyc += 1; d++;
        end else begin
          e_cyc += 3; e_reads++;
          if (vis[nr*16+nc]) d++;
          else if (stk.size() == depth) begin
            e_fail = 1; e_ovf = 1; fin = 1;
          end else begin
            stk.push_back(d);
            r = nr; c = nc; d = 0;
            vis[r*16+c] = 1'b1;
            e_writes++; e_cyc += 2;
            if (r == gr && c == gc) begin
              e_done = 1; fin = 1;
            end
          end
        end
      end
    end
    path = stk;
  endtask

  task automatic load_ram(input logic [NC-1:0] mz);
    maze_img = mz;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy0"}, bus0.busy, 0);     chk({tag, "_busy1"}, bus1.busy, 0);
    chk({tag, "_done0"}, bus0.done, 0);     chk({tag, "_done1"}, bus1.done, 0);
    chk({tag, "_fail0"}, bus0.fail, 0);     chk({tag, "_fail1"}, bus1.fail, 0);
    chk({tag, "_ovf0"}, bus0.overflow, 0);  chk({tag, "_ovf1"}, bus1.overflow, 0);
    chk({tag, "_len0"}, bus0.path_len, 0);  chk({tag, "_len1"}, bus1.path_len, 0);
    chk({tag, "_move0"}, bus0.move, 0);     chk({tag, "_move1"}, bus1.move, 0);
    chk({tag, "_mdir0"}, bus0.move_dir, 0); chk({tag, "_mdir1"}, bus1.move_dir, 0);
    chk({tag, "_rd0"}, bus0.mem_rd, 0);     chk({tag, "_wr0"}, bus0.mem_wr, 0);
    chk({tag, "_addr0"}, bus0.mem_addr, 0); chk({tag, "_addr1"}, bus1.mem_addr, 0);
  endtask

  task automatic run_case(input string tag, input logic [NC-1:0] mz,
                          input int sr, input int sc, input int gr, input int gc);
    int ed0, ef0, eo0, er0, ew0, ec0, ed1, ef1, eo1, er1, ew1, ec1;
    int p0[$], p1[$];
    int brd0, bwr0, bdb0, bmv0, brd1, bwr1, bdb1, bmv1;
    int t0, t1, wait_n;
    model_solve(mz, sr, sc, gr, gc, D0, ed0, ef0, eo0, er0, ew0, ec0, p0);
    model_solve(mz, sr, sc, gr, gc, D1, ed1, ef1, eo1, er1, ew1, ec1, p1);
    load_ram(mz);
    brd0 = rd0; bwr0 = wr0; bdb0 = dbl0; bmv0 = mv0.size();
    brd1 = rd1; bwr1 = wr1; bdb1 = dbl1; bmv1 = mv1.size();
    s_row = RW'(sr); s_col = CW'(sc); g_row = RW'(gr); g_col = CW'(gc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_mark_wr"}, bus0.mem_wr, 1);
    chk({tag, "_mark_addr"}, bus0.mem_addr, sr*16 + sc);
    chk({tag, "_busy"}, bus0.busy, 1);
    t0 = -1; t1 = -1;
    for (int n = 1; n <= BOUND; n++) begin
      if (t0 < 0 && (bus0.done || bus0.fail)) t0 = n;
      if (t1 < 0 && (bus1.done || bus1.fail)) t1 = n;
      if (t0 >= 0 && t1 >= 0) break;
      @(negedge clk);
    end
    chk({tag, "_cyc0"}, t0 - 1, ec0);       chk({tag, "_cyc1"}, t1 - 1, ec1);
    chk({tag, "_done0"}, bus0.done, ed0);   chk({tag, "_done1"}, bus1.done, ed1);
    chk({tag, "_fail0"}, bus0.fail, ef0);   chk({tag, "_fail1"}, bus1.fail, ef1);
    chk({tag, "_ovf0"}, bus0.overflow, eo0); chk({tag, "_ovf1"}, bus1.overflow, eo1);
    chk({tag, "_len0"}, bus0.path_len, p0.size());
    chk({tag, "_len1"}, bus1.path_len, p1.size());
    chk({tag, "_idle0"}, bus0.busy, 0);     chk({tag, "_idle1"}, bus1.busy, 0);
    chk({tag, "_reads0"}, rd0 - brd0, er0); chk({tag, "_reads1"}, rd1 - brd1, er1);
    chk({tag, "_writes0"}, wr0 - bwr0, ew0); chk({tag, "_writes1"}, wr1 - bwr1, ew1);
    chk({tag, "_rewrite0"}, dbl0 - bdb0, 0); chk({tag, "_rewrite1"}, dbl1 - bdb1, 0);

    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_n = (p0.size() > p1.size() ? p0.size() : p1.size()) + 4;
    repeat (wait_n) @(negedge clk);
    chk({tag, "_nmove0"}, mv0.size() - bmv0, ed0 ? p0.size() : 0);
    chk({tag, "_nmove1"}, mv1.size() - bmv1, ed1 ? p1.size() : 0);
    for (int i = 0; i < p0.size() && bmv0 + i < mv0.size(); i++) begin
      chk({tag, "_mdir0"}, mv0[bmv0+i], p0[i]);
      if (i > 0) chk({tag, "_mgap0"}, mc0[bmv0+i] - mc0[bmv0+i-1], 1);
    end
    for (int i = 0; i < p1.size() && bmv1 + i < mv1.size(); i++) begin
      chk({tag, "_mdir1"}, mv1[bmv1+i], p1[i]);
      if (i > 0) chk({tag, "_mgap1"}, mc1[bmv1+i] - mc1[bmv1+i-1], 1);
    end
    chk({tag, "_rp_done0"}, bus0.done, ed0);
    chk({tag, "_rp_len0"}, bus0.path_len, p0.size());
    chk({tag, "_rp_busy0"}, bus0.busy, 0);
  endtask

  logic [NC-1:0] mz;
  int sr, sc, gr, gc;

  initial begin
    rst = 1'b1; start = 1'b0; run = 1'b0;
    s_row = '0; s_col = '0; g_row = '0; g_col = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // start == goal: immediate done, empty path
    mz = '0;
    run_case("same", mz, 3, 5, 3, 5);
    chk("same_len", bus0.path_len, 0);

    // open maze, straight east along row 0
    run_case("east3", mz, 0, 0, 0, 3);
    chk("east3_len", bus0.path_len, 3);
    chk("east3_last", mv0[mv0.size()-1], 1);

    // start boxed in: fail through back-track with empty stack
    mz = '0; mz[0*16+1] = 1'b1; mz[1*16+0] = 1'b1;
    run_case("boxed", mz, 0, 0, 5, 5);
    chk("boxed_fail", bus0.fail, 1);
    chk("boxed_ovf", bus0.overflow, 0);
    chk("boxed_done", bus0.done, 0);

    // dead-end branch to the north, real path to the south
    mz = '1;
    mz[8*16+8] = 1'b0; mz[7*16+8] = 1'b0; mz[6*16+8] = 1'b0;
    mz[9*16+8] = 1'b0; mz[10*16+8] = 1'b0;
    run_case("deadend", mz, 8, 8, 10, 8);
    chk("deadend_len", bus0.path_len, 2);
    chk("deadend_dir", mv0[mv0.size()-1], 2);

    // corridor of length 6: the depth-4 solver overflows on the fifth push
    mz = '1;
    for (int i = 0; i < 6; i++) mz[i] = 1'b0;
    run_case("corr", mz, 0, 0, 0, 5);
    chk("corr_len0", bus0.path_len, 5);
    chk("corr_ovf1", bus1.overflow, 1);
    chk("corr_fail1", bus1.fail, 1);
    chk("corr_len1", bus1.path_len, 4);

    // randomised mazes
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < NC; i++) mz[i] = ($urandom_range(0, 99) < 38);
      sr = $urandom_range(0, 15); sc = $urandom_range(0, 15);
      gr = $urandom_range(0, 15); gc = $urandom_range(0, 15);
      mz[sr*16+sc] = 1'b0; mz[gr*16+gc] = 1'b0;
      run_case($sformatf("rand%0d", k), mz, sr, sc, gr, gc);
    end

    // reset mid-solve, then a fresh solve on a reloaded maze
    mz = '0;
    load_ram(mz);
    s_row = '0; s_col = '0; g_row = '1; g_col = '1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_busy", bus0.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NC; i++) mz[i] = ($urandom_range(0, 99) < 30);
    mz[2*16+2] = 1'b0; mz[12*16+9] = 1'b0;
    run_case("post_rst", mz, 2, 2, 12, 9);

    chk("rdwr_excl0", excl0, 0);
    chk("rdwr_excl1", excl1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
